// File: rtl/mlcd_reg_reader.sv
// 8080-style MCU LCD read controller: writes one command word (RS=0), releases
// the bus, then issues rd_num (+ optional dummy) read strobes and returns each word.
module mlcd_reg_reader #(
  parameter int unsigned WR_LOW   = 2,
  parameter int unsigned WR_HIGH  = 2,
  parameter int unsigned TURN     = 1,
  parameter int unsigned RD_LOW   = 4,
  parameter int unsigned RD_HIGH  = 2,
  parameter int unsigned DUMMY_RD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] cmd,
  input  logic [3:0]  rd_num,
  output logic        busy,
  output logic        done,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic [3:0]  rd_idx,
  output logic        mlcd_cs_n,
  output logic        mlcd_wr_n,
  output logic        mlcd_rd_n,
  output logic        mlcd_rs,
  output logic        mlcd_data_dir,
  output logic [15:0] mlcd_data_out,
  input  logic [15:0] mlcd_data_in
);

  // Phase lengths minus one; a zero-length strobe phase is stretched to one cycle.
  localparam logic [7:0] WL_M1 = 8'((WR_LOW  == 0) ? 0 : WR_LOW  - 1);
  localparam logic [7:0] WH_M1 = 8'((WR_HIGH == 0) ? 0 : WR_HIGH - 1);
  localparam logic [7:0] TU_M1 = 8'((TURN    == 0) ? 0 : TURN    - 1);
  localparam logic [7:0] RL_M1 = 8'((RD_LOW  == 0) ? 0 : RD_LOW  - 1);
  localparam logic [7:0] RH_M1 = 8'((RD_HIGH == 0) ? 0 : RD_HIGH - 1);
  localparam logic       DUM   = (DUMMY_RD != 0);
  localparam logic       HAS_TURN = (TURN != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_L, S_CMD_H, S_TURN, S_RD_L, S_RD_H, S_DONE
  } state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [4:0]  left_q;   // reads still to strobe, dummy included
  logic        dummy_q;  // next read is the discarded one
  logic [3:0]  word_q;   // index the next real word will carry
  logic        busy_q, done_q, rd_valid_q;
  logic [15:0] rd_data_q, data_out_q;
  logic [3:0]  rd_idx_q;
  logic        cs_n_q, wr_n_q, rd_n_q, rs_q, dir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      left_q     <= '0;
      dummy_q    <= 1'b0;
      word_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      data_out_q <= '0;
      cs_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      rs_q       <= 1'b1;
      dir_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q    <= S_CMD_L;
          cnt_q      <= '0;
          left_q     <= {1'b0, rd_num} + {4'd0, DUM};
          dummy_q    <= DUM;
          word_q     <= '0;
          rd_idx_q   <= '0;
          busy_q     <= 1'b1;
          data_out_q <= cmd;
          cs_n_q     <= 1'b0;
          rs_q       <= 1'b0;
          dir_q      <= 1'b1;
          wr_n_q     <= 1'b0;
        end
        S_CMD_L: if (cnt_q == WL_M1) begin
          cnt_q   <= '0;
          wr_n_q  <= 1'b1;
          state_q <= S_CMD_H;
        end else cnt_q <= cnt_q + 8'd1;
        S_CMD_H: if (cnt_q == WH_M1) begin
          cnt_q <= '0;
          rs_q  <= 1'b1;
          dir_q <= 1'b0;
          if (left_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
          end else if (HAS_TURN) begin
            state_q <= S_TURN;
          end else begin
            state_q <= S_RD_L;
            rd_n_q  <= 1'b0;
          end
        end else cnt_q <= cnt_q + 8'd1;
        S_TURN: if (cnt_q == TU_M1) begin
          cnt_q   <= '0;
          rd_n_q  <= 1'b0;
          state_q <= S_RD_L;
        end else cnt_q <= cnt_q + 8'd1;
        // Pad value is sampled on the edge that closes the low phase.
        S_RD_L: if (cnt_q == RL_M1) begin
          cnt_q   <= '0;
          rd_n_q  <= 1'b1;
          state_q <= S_RD_H;
          left_q  <= left_q - 5'd1;
          dummy_q <= 1'b0;
          if (!dummy_q) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= mlcd_data_in;
            rd_idx_q   <= word_q;
            word_q     <= word_q + 4'd1;
          end
        end else cnt_q <= cnt_q + 8'd1;
        S_RD_H: if (cnt_q == RH_M1) begin
          cnt_q <= '0;
          if (left_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
          end else begin
            state_q <= S_RD_L;
            rd_n_q  <= 1'b0;
          end
        end else cnt_q <= cnt_q + 8'd1;
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign rd_idx        = rd_idx_q;
  assign mlcd_cs_n     = cs_n_q;
  assign mlcd_wr_n     = wr_n_q;
  assign mlcd_rd_n     = rd_n_q;
  assign mlcd_rs       = rs_q;
  assign mlcd_data_dir = dir_q;
  assign mlcd_data_out = data_out_q;

endmodule

// File: tb/tb_mlcd_reg_reader.sv
// Bench for mlcd_reg_reader: three parameter sets share one stimulus; a
// phase-arithmetic model predicts every output each cycle.
module tb_mlcd_reg_reader;
  localparam int NI = 3;
  localparam int P_WL [NI] = '{2, 0, 2};
  localparam int P_WH [NI] = '{2, 0, 2};
  localparam int P_TU [NI] = '{1, 0, 0};
  localparam int P_RL [NI] = '{4, 0, 1};
  localparam int P_RH [NI] = '{2, 0, 1};
  localparam int P_DM [NI] = '{1, 1, 0};

  logic        clk, rst_n, start;
  logic [15:0] cmd;
  logic [3:0]  rd_num;

  logic        busy_w [NI], done_w [NI], vld_w [NI], cs_n_w [NI], wr_n_w [NI];
  logic        rd_n_w [NI], rs_w [NI], dir_w [NI];
  logic [15:0] rd_data_w [NI], dout_w [NI];
  logic [3:0]  rd_idx_w [NI];
  int          falls_w [NI];

  int checks = 0, errors = 0, cyc = 0;

  // Model state per instance
  bit          act [NI];
  int          o [NI], n [NI], base [NI], vcnt [NI];
  logic [15:0] mcmd [NI], ldata [NI];
  logic [3:0]  lidx [NI];

  function automatic logic [15:0] busval(int i);
    logic [15:0] tbl [4];
    tbl = '{16'h0000, 16'h0000, 16'h0093, 16'h0041};
    if (i < 4) return tbl[i];
    return 16'(i * 16'h1357) ^ 16'hA5A5;
  endfunction

  function automatic int eff(int x);
    return (x == 0) ? 1 : x;
  endfunction

  initial clk = 1'b0;
  always #10 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    logic [15:0] din = '0;
    int          falls = 0;
    // Pad model: a fresh word is presented on every rd_n fall.
    always @(negedge rd_n_w[g]) begin
      din   <= busval(falls);
      falls <= falls + 1;
    end
    assign falls_w[g] = falls;

    mlcd_reg_reader #(
      .WR_LOW(P_WL[g]), .WR_HIGH(P_WH[g]), .TURN(P_TU[g]),
      .RD_LOW(P_RL[g]), .RD_HIGH(P_RH[g]), .DUMMY_RD(P_DM[g])
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .rd_num(rd_num),
      .busy(busy_w[g]), .done(done_w[g]), .rd_valid(vld_w[g]),
      .rd_data(rd_data_w[g]), .rd_idx(rd_idx_w[g]),
      .mlcd_cs_n(cs_n_w[g]), .mlcd_wr_n(wr_n_w[g]), .mlcd_rd_n(rd_n_w[g]),
      .mlcd_rs(rs_w[g]), .mlcd_data_dir(dir_w[g]), .mlcd_data_out(dout_w[g]),
      .mlcd_data_in(din)
    );
  end

  task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d actual=%0h expected=%0h", nm, g, cyc, a, e);
    end
  endtask

  function automatic int done_off(int g, int nn);
    int tot = nn + P_DM[g];
    int tu  = (tot > 0) ? P_TU[g] : 0;
    return eff(P_WL[g]) + eff(P_WH[g]) + tu + tot * (eff(P_RL[g]) + eff(P_RH[g])) + 1;
  endfunction

  task automatic model_update();
    for (int g = 0; g < NI; g++) begin
      bit was = act[g];
      if (!rst_n) begin
        act[g] = 0; ldata[g] = '0; lidx[g] = '0;
      end else begin
        if (act[g]) begin
          o[g]++;
          if (o[g] > done_off(g, n[g])) act[g] = 0;
        end
        if (!was && start) begin
          act[g] = 1; o[g] = 1; n[g] = int'(rd_num); mcmd[g] = cmd;
          base[g] = falls_w[g]; lidx[g] = '0; vcnt[g] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < NI; g++) begin
      logic ecs = 1, ewr = 1, erd = 1, ers = 1, edir = 0, ebusy = 0, edone = 0, evld = 0;
      if (act[g]) begin
        int wl = eff(P_WL[g]), wh = eff(P_WH[g]), rl = eff(P_RL[g]), rh = eff(P_RH[g]);
        int tot = n[g] + P_DM[g];
        int a = wl, b = wl + wh, c = wl + wh + ((tot > 0) ? P_TU[g] : 0);
        int l = done_off(g, n[g]);
        ecs = 0; ebusy = 1;
        if (o[g] <= a) begin ewr = 0; ers = 0; edir = 1; end
        else if (o[g] <= b) begin ers = 0; edir = 1; end
        else if (o[g] <= c) begin end
        else if (o[g] < l) begin
          int r  = (o[g] - c - 1) / (rl + rh);
          int ph = (o[g] - c - 1) % (rl + rh);
          erd = (ph < rl) ? 1'b0 : 1'b1;
          if (ph == rl && r >= P_DM[g]) begin
            evld = 1; ldata[g] = busval(base[g] + r); lidx[g] = 4'(r - P_DM[g]);
          end
        end else begin
          ecs = 1; ebusy = 0; edone = 1;
        end
        if (vld_w[g]) vcnt[g]++;
        if (o[g] == l) chk("pulse_count", g, vcnt[g], n[g]);
      end
      chk("cs_n", g, cs_n_w[g], ecs);
      chk("wr_n", g, wr_n_w[g], ewr);
      chk("rd_n", g, rd_n_w[g], erd);
      chk("rs", g, rs_w[g], ers);
      chk("data_dir", g, dir_w[g], edir);
      chk("busy", g, busy_w[g], ebusy);
      chk("done", g, done_w[g], edone);
      chk("rd_valid", g, vld_w[g], evld);
      chk("rd_data", g, rd_data_w[g], ldata[g]);
      chk("rd_idx", g, rd_idx_w[g], lidx[g]);
      if (edir) chk("data_out", g, dout_w[g], mcmd[g]);
      chk("strobe_overlap", g, !wr_n_w[g] && !rd_n_w[g], 0);
      chk("dir_in_read", g, !rd_n_w[g] && dir_w[g], 0);
      chk("cs_while_busy", g, busy_w[g] && cs_n_w[g], 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
    model_update();
    compare_all();
  endtask

  function automatic bit any_act();
    for (int g = 0; g < NI; g++) if (act[g]) return 1;
    return 0;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (any_act() && k < 300) begin tick(); k++; end
    checks++;
    if (any_act()) begin errors++; $display("FAIL idle_timeout cyc%0d actual=busy expected=idle", cyc); end
    tick();
  endtask

  task automatic issue(input logic [15:0] c, input logic [3:0] nn);
    start = 1; cmd = c; rd_num = nn; cyc = 0;
    tick();
    start = 0;
  endtask

  initial begin
    rst_n = 0; start = 0; cmd = '0; rd_num = '0;
    for (int g = 0; g < NI; g++) begin
      act[g] = 0; o[g] = 0; n[g] = 0; base[g] = 0; vcnt[g] = 0;
      mcmd[g] = '0; ldata[g] = '0; lidx[g] = '0;
    end
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("rst_cs_n", 0, cs_n_w[0], 1);
    chk("rst_rs", 0, rs_w[0], 1);
    chk("rst_dout", 0, dout_w[0], 0);
    chk("rst_rd_data", 0, rd_data_w[0], 0);

    // ID readback: cmd 0xD3, three words after a dummy
    issue(16'h00D3, 4'd3);
    chk("t1_wr_low", 0, {wr_n_w[0], rs_w[0], dout_w[0]}, {2'b00, 16'h00D3});
    while (cyc < 30) begin
      tick();
      case (cyc)
        2:  chk("t1_wr_low2", 0, wr_n_w[0], 0);
        3:  chk("t1_wr_high", 0, wr_n_w[0], 1);
        16: chk("t1_w0", 0, {vld_w[0], rd_idx_w[0], rd_data_w[0]}, {1'b1, 4'd0, 16'h0000});
        22: chk("t1_w1", 0, {vld_w[0], rd_idx_w[0], rd_data_w[0]}, {1'b1, 4'd1, 16'h0093});
        28: chk("t1_w2", 0, {vld_w[0], rd_idx_w[0], rd_data_w[0]}, {1'b1, 4'd2, 16'h0041});
        30: chk("t1_done", 0, done_w[0], 1);
        default: ;
      endcase
    end
    wait_idle();

    // Zero reads on the no-dummy instance
    issue(16'h0029, 4'd0);
    while (cyc < 5) tick();
    chk("t2_done5", 2, done_w[2], 1);
    wait_idle();

    // Starts while busy and in DONE are dropped; the one after DONE is taken
    issue(16'h00D3, 4'd3);
    while (cyc < 40) begin
      if (cyc == 3 || cyc == 20 || cyc == 30 || cyc == 31) begin
        start = 1;
        cmd = (cyc == 31) ? 16'h1234 : 16'hBEEF;
        rd_num = (cyc == 31) ? 4'd1 : 4'd7;
      end
      tick();
      start = 0;
      if (cyc == 4) chk("t3_cmd_kept", 0, dout_w[0], 16'h00D3);
      if (cyc == 31) chk("t3_done_cs", 0, cs_n_w[0], 1);
      if (cyc == 32) chk("t3_restart", 0, {cs_n_w[0], dout_w[0]}, {1'b0, 16'h1234});
    end
    wait_idle();

    // Reset in the middle of a read strobe
    issue(16'h00D3, 4'd3);
    while (cyc < 13) tick();
    rst_n = 0;
    #1;
    chk("t4_async", 0, {cs_n_w[0], rd_n_w[0], busy_w[0], rs_w[0], dir_w[0]}, 5'b11010);
    chk("t4_dout", 0, dout_w[0], 0);
    chk("t4_rd_data", 0, rd_data_w[0], 0);
    tick();
    rst_n = 1;
    repeat (30) tick();
    issue(16'h0004, 4'd2);
    wait_idle();

    // Random traffic, including starts while busy
    for (int i = 0; i < 1500; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      cmd    = 16'($urandom);
      rd_num = 4'($urandom);
      tick();
    end
    start = 0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mlcd_reg_reader.md
Name: mlcd_reg_reader

Overview:
- 8080-style MCU LCD bus read controller: the read direction of the existing MCU LCD write path.
- On `start` it writes one command word with RS=0, releases the data bus, then performs N read strobes with RS=1 and returns each sampled word.
- Used for controller ID readback (e.g. 0xD3/0x04) and GRAM/status readback.
- Its bus outputs feed the LCD signal selector alongside the init and driver sources; the tri-state pad itself lives in the selector, not here.

Parameters:
- WR_LOW, 2, cycles wr_n held low per command write (1..255; 0 behaves as 1)
- WR_HIGH, 2, cycles wr_n held high after the write edge (1..255; 0 behaves as 1)
- TURN, 1, bus-turnaround cycles after data_dir release and before the first rd_n low (0..255)
- RD_LOW, 4, cycles rd_n held low per read (1..255; 0 behaves as 1)
- RD_HIGH, 2, cycles rd_n held high after each read (1..255; 0 behaves as 1)
- DUMMY_RD, 1, 1 = perform and discard one leading dummy read; 0 = none

Ports:
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request; accepted only when busy=0
- cmd  input  16  command word to write
- rd_num  input  4  number of data words to return (0..15)
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at end of transaction
- rd_valid  output  1  one-cycle pulse, rd_data valid
- rd_data  output  16  sampled read word
- rd_idx  output  4  index (0-based) of the word on rd_data
- mlcd_cs_n  output  1  chip select, active-low
- mlcd_wr_n  output  1  write strobe, active-low
- mlcd_rd_n  output  1  read strobe, active-low
- mlcd_rs  output  1  0 = command, 1 = data
- mlcd_data_dir  output  1  1 = drive mlcd_data_out onto the bus, 0 = release
- mlcd_data_out  output  16  bus drive value
- mlcd_data_in  input  16  bus value from pad

Behaviour:
- Reset (async; all outputs registered):
  - cs_n=1, wr_n=1, rd_n=1, rs=1, data_dir=0, data_out=0
  - busy=0, done=0, rd_valid=0, rd_data=0, rd_idx=0
  - FSM=IDLE
  - Reset asserted mid-transaction returns to these values immediately. No partial results are reported.
- FSM states: IDLE, CMD_L, CMD_H, TURN, RD_L, RD_H, DONE.
- IDLE:
  - On start=1, latch cmd and rd_num, set busy=1.
  - start while busy=1 is ignored; the latched values are unaffected.
- CMD_L (entered the cycle after start, cycle 1):
  - cs_n=0, rs=0, data_dir=1, data_out=cmd, wr_n=0, held for WR_LOW cycles.
- CMD_H:
  - wr_n=1, data still driven, held WR_HIGH cycles.
- TURN:
  - rs=1, data_dir=0, held TURN cycles; skipped if TURN=0.
- RD_L / RD_H loop:
  - Total reads = rd_num + DUMMY_RD.
  - RD_L holds rd_n=0 for RD_LOW cycles.
  - mlcd_data_in is captured at the clock edge that ends the last RD_L cycle.
  - RD_H holds rd_n=1 for RD_HIGH cycles.
  - For non-dummy reads, rd_valid=1 with rd_data/rd_idx in the first RD_H cycle.
  - The dummy read never pulses rd_valid.
  - rd_idx counts 0..rd_num-1.
- Zero reads (rd_num=0 and DUMMY_RD=0): go CMD_H -> DONE after WR_HIGH; no TURN, no rd_n activity.
- DONE (one cycle): cs_n=1, rs=1, data_dir=0, done=1, busy=0. Next state IDLE.
  - start in the DONE cycle is ignored.
  - start in the following cycle is accepted.
- Hold rules:
  - rd_data holds its last value between pulses and after done.
  - rd_idx resets to 0 at each new start.
- Strobe rules:
  - wr_n and rd_n are never low simultaneously.
  - data_dir=1 only while rs=0 during the command phase.
- Timing (defaults, dummy + rd_num=3, start at cycle 0):
  - cycles 1-2 wr_n low, 3-4 high, 5 turnaround.
  - Dummy: 6-9 low, 10-11 high.
  - Word 0: 12-15 low, rd_valid at 16.
  - Word 1: rd_valid at 22.
  - Word 2: rd_valid at 28.
  - done at cycle 30.

Test Plan:
- Defaults, cmd=0x00D3, rd_num=3, bus model returns 0x0000/0x0000/0x0093/0x0041 on successive rd_n falls:
  - wr_n low cycles 1-2 with data_out=0x00D3 and rs=0.
  - rd_valid at cycles 16/22/28 with rd_data 0x0000/0x0093/0x0041 and rd_idx 0/1/2.
  - done at cycle 30.
- rd_num=0, DUMMY_RD=0, cmd=0x0029:
  - One wr_n pulse only; rd_n never low; rd_valid never pulses.
  - done at cycle 5.
- start pulsed at cycles 3 and 20 during a transaction, then at cycle 30 (DONE) and cycle 31:
  - The first three are ignored; latched cmd is unchanged.
  - The cycle-31 start is accepted: cs_n low again at cycle 32.
- rst_n pulled low at cycle 13 mid-read:
  - All outputs reach reset values asynchronously.
  - No rd_valid or done appears after release.
  - A new start then completes normally.
- Protocol monitor across random cmd/rd_num and parameter sets (incl. TURN=0, RD_LOW=1, zero-valued params):
  - wr_n and rd_n are never both low.
  - data_dir=0 whenever rd_n=0.
  - cs_n=0 for the entire transaction.
  - Exactly rd_num rd_valid pulses per transaction.
